// File: rtl/button_conditioner.sv
// Push-button front end: synchronise, debounce, flag presses and long presses,
// and turn a long press on one chosen button into a fixed-width reset request.
module button_conditioner #(
  parameter int N_BTN           = 2,
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int LONG_CYCLES     = 100000000,
  parameter int RST_PULSE       = 16,
  parameter int RST_BTN         = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw_i,
  output logic [N_BTN-1:0] btn_level_o,
  output logic [N_BTN-1:0] press_evt_o,
  output logic [N_BTN-1:0] long_evt_o,
  input  logic [N_BTN-1:0] evt_clr_i,
  output logic             rst_req_o
);

  localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HOLD_W = $clog2(LONG_CYCLES) + 1;
  localparam int PLS_W  = $clog2(RST_PULSE) + 1;

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [PLS_W-1:0]  PLS_LAST  = PLS_W'(RST_PULSE - 1);
  // Pin level of an untouched button; also the XOR mask that normalises to 1 = pressed.
  localparam logic [N_BTN-1:0]  RELEASED  = (ACTIVE_LOW != 0) ? {N_BTN{1'b1}} : '0;

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_bad_long
    $error("LONG_CYCLES must exceed DEBOUNCE_CYCLES");
  end
  if (RST_PULSE < 1) begin : g_bad_pls
    $error("RST_PULSE must be at least 1");
  end
  if (RST_BTN < 0 || RST_BTN >= N_BTN) begin : g_bad_rbtn
    $error("RST_BTN must index an existing button");
  end

  typedef enum logic [1:0] {IDLE, PULSE, WAIT_REL} state_t;

  logic [N_BTN-1:0]  sync1_q, sync2_q;
  logic [N_BTN-1:0]  pressed;
  logic [N_BTN-1:0]  level_q, level_d, level_dly_q;
  logic [N_BTN-1:0]  press_q, press_d;
  logic [N_BTN-1:0]  long_q, long_d;
  logic [N_BTN-1:0]  long_hit;
  logic [DEB_W-1:0]  deb_q  [N_BTN];
  logic [DEB_W-1:0]  deb_d  [N_BTN];
  logic [HOLD_W-1:0] hold_q [N_BTN];
  logic [HOLD_W-1:0] hold_d [N_BTN];

  state_t            state_q;
  logic [PLS_W-1:0]  pls_q;
  logic              rst_req_q;

  assign pressed = sync2_q ^ RELEASED;

  always_comb begin
    level_d  = level_q;
    long_hit = '0;
    for (int i = 0; i < N_BTN; i++) begin
      deb_d[i]  = '0;
      hold_d[i] = '0;
      if (pressed[i] != level_q[i]) begin
        if (deb_q[i] == DEB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_d[i] = deb_q[i] + 1'b1;
        end
      end
      if (level_q[i]) begin
        hold_d[i]   = (hold_q[i] == HOLD_MAX) ? hold_q[i] : hold_q[i] + 1'b1;
        long_hit[i] = (hold_q[i] == HOLD_LAST);
      end
    end
    // A new event in the same cycle as a clear must survive.
    press_d = (level_q & ~level_dly_q) | (press_q & ~evt_clr_i);
    long_d  = long_hit | (long_q & ~evt_clr_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= RELEASED;
      sync2_q     <= RELEASED;
      level_q     <= '0;
      level_dly_q <= '0;
      press_q     <= '0;
      long_q      <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        deb_q[i]  <= '0;
        hold_q[i] <= '0;
      end
    end else begin
      sync1_q     <= btn_raw_i;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      long_q      <= long_d;
      for (int i = 0; i < N_BTN; i++) begin
        deb_q[i]  <= deb_d[i];
        hold_q[i] <= hold_d[i];
      end
    end
  end

  // WAIT_REL holds off re-triggering until the reset button has been let go.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pls_q     <= '0;
      rst_req_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (long_hit[RST_BTN]) begin
            state_q   <= PULSE;
            pls_q     <= '0;
            rst_req_q <= 1'b1;
          end
        end
        PULSE: begin
          if (pls_q == PLS_LAST) begin
            state_q   <= WAIT_REL;
            rst_req_q <= 1'b0;
          end else begin
            pls_q <= pls_q + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!level_q[RST_BTN]) state_q <= IDLE;
        end
        default: begin
          state_q   <= IDLE;
          rst_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign btn_level_o = level_q;
  assign press_evt_o = press_q;
  assign long_evt_o  = long_q;
  assign rst_req_o   = rst_req_q;

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter N_BTN, default 2: number of push-button inputs conditioned.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 means the raw pin reads 0 when pressed.
REQ-003 Parameter DEBOUNCE_CYCLES, default 500000: input stability window, in clk cycles (10 ms at 50 MHz); minimum 2.
REQ-004 Parameter LONG_CYCLES, default 100000000: debounced hold time that constitutes a long press (2 s at 50 MHz); must exceed DEBOUNCE_CYCLES.
REQ-005 Parameter RST_PULSE, default 16: width of rst_req_o pulse in clk cycles; minimum 1.
REQ-006 Parameter RST_BTN, default 0: index of the button whose long press requests a reset.
REQ-007 clk  input  1  single clock; all state in this domain.
REQ-008 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-009 btn_raw_i  input  N_BTN  raw asynchronous button pins.
REQ-010 btn_level_o  output  N_BTN  debounced level, 1 = pressed, regardless of ACTIVE_LOW.
REQ-011 press_evt_o  output  N_BTN  sticky press-event flags.
REQ-012 long_evt_o  output  N_BTN  sticky long-press flags.
REQ-013 evt_clr_i  input  N_BTN  write-1-to-clear strobe for both sticky flags of that bit.
REQ-014 rst_req_o  output  1  active-high reset-request pulse to the PS-side reset block.

Function
REQ-015 Each btn_raw_i bit SHALL pass through a 2-flop synchronizer, then be normalised to 1 = pressed per ACTIVE_LOW.
REQ-016 Per button, a debounce counter SHALL clear whenever the synchronized level equals btn_level_o and increment otherwise.
REQ-017 When the debounce counter reaches DEBOUNCE_CYCLES-1 while still mismatched, btn_level_o SHALL toggle on the next edge and the counter SHALL clear.
REQ-018 Latency from a clean raw edge to btn_level_o change SHALL be exactly 2 + DEBOUNCE_CYCLES cycles.
REQ-019 A glitch shorter than DEBOUNCE_CYCLES cycles (post-sync) SHALL produce no change on btn_level_o.
REQ-020 press_evt_o[i] SHALL set on the cycle after btn_level_o[i] rises 0->1; release produces no event.
REQ-021 A per-button hold counter SHALL clear while btn_level_o[i]=0, increment while 1, and saturate at LONG_CYCLES.
REQ-022 long_evt_o[i] SHALL set exactly once per press, on the cycle the hold counter first reaches LONG_CYCLES.
REQ-023 evt_clr_i[i]=1 SHALL clear press_evt_o[i] and long_evt_o[i] on the next edge.
REQ-024 If set and clear coincide on the same bit in the same cycle, set SHALL win (flag ends at 1).
REQ-025 Pulse FSM states: IDLE, PULSE, WAIT_REL.
- IDLE -> PULSE when the long-press condition of REQ-022 fires for RST_BTN.
- PULSE drives rst_req_o=1 for exactly RST_PULSE cycles, then -> WAIT_REL.
- WAIT_REL -> IDLE when btn_level_o[RST_BTN]=0.
REQ-026 rst_req_o SHALL be registered, glitch-free, and 0 in IDLE and WAIT_REL.
REQ-027 A release during PULSE SHALL NOT shorten the pulse; the FSM proceeds to WAIT_REL and leaves it on the next cycle.
REQ-028 Counter widths SHALL be $clog2 of their terminal values plus 1; no counter SHALL wrap.

Reset
REQ-029 On rst_n=0, all of the following SHALL be cleared: synchronizer flops (to released level), debounce and hold counters, btn_level_o, press_evt_o, long_evt_o, rst_req_o; FSM SHALL enter IDLE.
REQ-030 Reset assertion mid-pulse SHALL drop rst_req_o immediately (asynchronously).
REQ-031 After reset deassertion with a button already held, the button SHALL register as a fresh press after 2 + DEBOUNCE_CYCLES cycles.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=10, RST_PULSE=3, ACTIVE_LOW=1)
REQ-032 Raw btn[1] 1->0 held -> btn_level_o[1]=1 exactly 6 cycles later; press_evt_o[1]=1 one cycle after that.
REQ-033 Raw btn[1] low for 3 cycles, then high -> btn_level_o and press_evt_o stay 0.
REQ-034 btn[0] held for 20 cycles -> long_evt_o[0] set once; rst_req_o high exactly 3 cycles; no second pulse until release and re-press.
REQ-035 evt_clr_i[1] pulsed in the same cycle press_evt_o[1] would set -> flag reads 1; a clear pulse one cycle later -> flag reads 0.
REQ-036 rst_n asserted during the rst_req_o pulse -> rst_req_o=0 immediately; with btn[0] still held at release, press_evt_o[0] sets after 7 cycles.
